// File: rtl/i2c_slave.sv
// I2C target with 7-bit addressing, oversampled SCL/SDA, open-drain SDA and no clock stretching.
// Optional: define I2C_SLAVE_GENCALL_EN to also ACK the general-call write address 8'h00.
module i2c_slave #(
    parameter logic [6:0] SLAVE_ADDR  = 7'h50,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scl,
    inout  wire        sda,
    input  logic [7:0] tx_data,
    output logic       tx_req,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       busy,
    output logic       addr_rw,
    output logic       nack_rcvd,
    output logic       stop_det
);
    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] ADDR      = 3'd1;
    localparam logic [2:0] ADDR_ACK  = 3'd2;
    localparam logic [2:0] RX        = 3'd3;
    localparam logic [2:0] RX_ACK    = 3'd4;
    localparam logic [2:0] TX        = 3'd5;
    localparam logic [2:0] TX_ACK    = 3'd6;
    localparam logic [2:0] WAIT_STOP = 3'd7;

    logic [SYNC_STAGES-1:0] r_sclSync;
    logic [SYNC_STAGES-1:0] r_sdaSync;
    logic                   r_sclPrev;
    logic                   r_sdaPrev;
    logic [2:0]             r_state;
    logic [2:0]             r_bitCnt;
    logic [7:0]             r_shift;
    logic                   r_ackPhase;
    logic                   r_sdaDrvLow;
    logic [7:0]             r_rxData;
    logic                   r_rxValid;
    logic                   r_txReq;
    logic                   r_busy;
    logic                   r_addrRw;
    logic                   r_nackRcvd;
    logic                   r_stopDet;

    logic       w_scl;
    logic       w_sda;
    logic       w_sclRise;
    logic       w_sclFall;
    logic       w_start;
    logic       w_stop;
    logic       w_addrMatch;
    logic [7:0] w_byteIn;

    assign sda = r_sdaDrvLow ? 1'b0 : 1'bz;

    assign w_scl     = r_sclSync[SYNC_STAGES-1];
    assign w_sda     = r_sdaSync[SYNC_STAGES-1];
    assign w_sclRise = w_scl & ~r_sclPrev;
    assign w_sclFall = ~w_scl & r_sclPrev;
    // Bus conditions require SCL high on both samples so an SDA change next to an SCL edge is not misread.
    assign w_start   = w_scl & r_sclPrev & r_sdaPrev & ~w_sda;
    assign w_stop    = w_scl & r_sclPrev & ~r_sdaPrev & w_sda;
    assign w_byteIn  = {r_shift[6:0], w_sda};

`ifdef I2C_SLAVE_GENCALL_EN
    assign w_addrMatch = (w_byteIn[7:1] == SLAVE_ADDR) || (w_byteIn == 8'h00);
`else
    assign w_addrMatch = (w_byteIn[7:1] == SLAVE_ADDR);
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sclSync <= '1;
            r_sdaSync <= '1;
            r_sclPrev <= 1'b1;
            r_sdaPrev <= 1'b1;
        end else begin
            r_sclSync <= {r_sclSync[SYNC_STAGES-2:0], scl};
            r_sdaSync <= {r_sdaSync[SYNC_STAGES-2:0], sda};
            r_sclPrev <= w_scl;
            r_sdaPrev <= w_sda;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_bitCnt    <= 3'd0;
            r_shift     <= 8'h00;
            r_ackPhase  <= 1'b0;
            r_sdaDrvLow <= 1'b0;
            r_rxData    <= 8'h00;
            r_rxValid   <= 1'b0;
            r_txReq     <= 1'b0;
            r_busy      <= 1'b0;
            r_addrRw    <= 1'b0;
            r_nackRcvd  <= 1'b0;
            r_stopDet   <= 1'b0;
        end else begin
            r_rxValid  <= 1'b0;
            r_txReq    <= 1'b0;
            r_nackRcvd <= 1'b0;
            r_stopDet  <= 1'b0;
            if (w_stop) begin
                r_state     <= IDLE;
                r_busy      <= 1'b0;
                r_stopDet   <= 1'b1;
                r_sdaDrvLow <= 1'b0;
                r_bitCnt    <= 3'd0;
            end else if (w_start) begin
                r_state     <= ADDR;
                r_bitCnt    <= 3'd0;
                r_sdaDrvLow <= 1'b0;
                r_ackPhase  <= 1'b0;
            end else begin
                case (r_state)
                    ADDR: begin
                        if (w_sclRise) begin
                            r_shift  <= w_byteIn;
                            r_bitCnt <= r_bitCnt + 3'd1;
                            if (r_bitCnt == 3'd7) begin
                                r_ackPhase <= 1'b0;
                                if (w_addrMatch) begin
                                    r_addrRw <= w_byteIn[0];
                                    r_busy   <= 1'b1;
                                    r_state  <= ADDR_ACK;
                                end else begin
                                    r_busy  <= 1'b0;
                                    r_state <= WAIT_STOP;
                                end
                            end
                        end
                    end
                    // First SCL fall starts the ACK pulse, the second one ends it and starts the data phase.
                    ADDR_ACK: begin
                        if (w_sclFall) begin
                            if (!r_ackPhase) begin
                                r_sdaDrvLow <= 1'b1;
                                r_ackPhase  <= 1'b1;
                            end else if (r_addrRw) begin
                                r_txReq     <= 1'b1;
                                r_shift     <= tx_data;
                                r_sdaDrvLow <= ~tx_data[7];
                                r_bitCnt    <= 3'd0;
                                r_state     <= TX;
                            end else begin
                                r_sdaDrvLow <= 1'b0;
                                r_state     <= RX;
                            end
                        end
                    end
                    RX: begin
                        if (w_sclRise) begin
                            r_shift  <= w_byteIn;
                            r_bitCnt <= r_bitCnt + 3'd1;
                            if (r_bitCnt == 3'd7) begin
                                r_rxData   <= w_byteIn;
                                r_rxValid  <= 1'b1;
                                r_ackPhase <= 1'b0;
                                r_state    <= RX_ACK;
                            end
                        end
                    end
                    RX_ACK: begin
                        if (w_sclFall) begin
                            if (!r_ackPhase) begin
                                r_sdaDrvLow <= 1'b1;
                                r_ackPhase  <= 1'b1;
                            end else begin
                                r_sdaDrvLow <= 1'b0;
                                r_state     <= RX;
                            end
                        end
                    end
                    TX: begin
                        if (w_sclFall) begin
                            if (r_bitCnt == 3'd7) begin
                                r_sdaDrvLow <= 1'b0;
                                r_bitCnt    <= 3'd0;
                                r_ackPhase  <= 1'b0;
                                r_state     <= TX_ACK;
                            end else begin
                                r_shift     <= {r_shift[6:0], 1'b0};
                                r_sdaDrvLow <= ~r_shift[6];
                                r_bitCnt    <= r_bitCnt + 3'd1;
                            end
                        end
                    end
                    TX_ACK: begin
                        if (!r_ackPhase && w_sclRise) begin
                            if (w_sda) begin
                                r_nackRcvd <= 1'b1;
                                r_state    <= WAIT_STOP;
                            end else begin
                                r_ackPhase <= 1'b1;
                            end
                        end else if (r_ackPhase && w_sclFall) begin
                            r_txReq     <= 1'b1;
                            r_shift     <= tx_data;
                            r_sdaDrvLow <= ~tx_data[7];
                            r_bitCnt    <= 3'd0;
                            r_state     <= TX;
                        end
                    end
                    default: begin
                        r_sdaDrvLow <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign tx_req    = r_txReq;
    assign rx_data   = r_rxData;
    assign rx_valid  = r_rxValid;
    assign busy      = r_busy;
    assign addr_rw   = r_addrRw;
    assign nack_rcvd = r_nackRcvd;
    assign stop_det  = r_stopDet;

endmodule

// File: tb/tb_i2c_slave.sv
// Bit-banged I2C master driving i2c_slave, with a transfer-level model of ACKs, received and returned bytes.
module tb_i2c_slave;
    localparam logic [6:0] SLAVE_ADDR = 7'h50;
    localparam int Q = 5;
`ifdef I2C_SLAVE_GENCALL_EN
    localparam bit GENCALL = 1'b1;
`else
    localparam bit GENCALL = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       scl = 1'b1;
    logic       sdaMasterLow = 1'b0;
    logic [7:0] tx_data = 8'h00;
    wire        sda;
    logic       tx_req;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy;
    logic       addr_rw;
    logic       nack_rcvd;
    logic       stop_det;

    int checkCount = 0;
    int passCount = 0;
    int txReqCnt = 0;
    int nackCnt = 0;
    int stopCnt = 0;
    int overlapCnt = 0;
    logic [7:0] rxLog[$];
    logic [7:0] wrBytes[4];
    logic [7:0] txBytes[4];

    assign sda = sdaMasterLow ? 1'b0 : 1'bz;
    pullup (sda);

    always #5 clk = ~clk;

    i2c_slave #(.SLAVE_ADDR(SLAVE_ADDR), .SYNC_STAGES(2)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .scl(scl),
        .sda(sda),
        .tx_data(tx_data),
        .tx_req(tx_req),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .busy(busy),
        .addr_rw(addr_rw),
        .nack_rcvd(nack_rcvd),
        .stop_det(stop_det)
    );

    always @(negedge clk) begin
        if (rx_valid) rxLog.push_back(rx_data);
        if (tx_req) txReqCnt++;
        if (nack_rcvd) nackCnt++;
        if (stop_det) stopCnt++;
        if (rx_valid && stop_det) overlapCnt++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed === expected) passCount++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    endtask

    function automatic bit addrMatch(input logic [7:0] a);
        return (a[7:1] == SLAVE_ADDR) || (GENCALL && a == 8'h00);
    endfunction

    task automatic waitClk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One SCL period starting and ending with SCL low; drive=1 releases SDA.
    task automatic applyStimulus(input logic drive, output logic sampled);
        waitClk(Q);
        sdaMasterLow = ~drive;
        waitClk(Q);
        scl = 1'b1;
        waitClk(Q);
        sampled = sda;
        waitClk(Q);
        scl = 1'b0;
    endtask

    task automatic startCond();
        sdaMasterLow = 1'b0;
        waitClk(Q);
        scl = 1'b1;
        waitClk(2 * Q);
        sdaMasterLow = 1'b1;
        waitClk(2 * Q);
        scl = 1'b0;
    endtask

    task automatic stopCond();
        sdaMasterLow = 1'b1;
        waitClk(Q);
        scl = 1'b1;
        waitClk(2 * Q);
        sdaMasterLow = 1'b0;
        waitClk(2 * Q);
    endtask

    task automatic writeByte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) applyStimulus(b[i], s);
        applyStimulus(1'b1, ack);
    endtask

    task automatic readByte(input logic masterAck, input logic [7:0] nextTx, output logic [7:0] b);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            applyStimulus(1'b1, s);
            b[i] = s;
        end
        tx_data = nextTx;
        applyStimulus(~masterAck, s);
    endtask

    // Full transfer: master ACKs every read byte except the last one.
    task automatic runTransfer(input logic [7:0] addrByte, input int n, input bit doStop);
        logic       ack;
        logic [7:0] got;
        int         rx0, tr0, nk0, st0;
        bit         match;
        match = addrMatch(addrByte);
        rx0 = rxLog.size();
        tr0 = txReqCnt;
        nk0 = nackCnt;
        tx_data = txBytes[0];
        startCond();
        writeByte(addrByte, ack);
        checkOutput("addrAck", ack, !match);
        checkOutput("busyAfterAddr", busy, match);
        if (match) checkOutput("addrRw", addr_rw, addrByte[0]);
        if (match && addrByte[0]) begin
            for (int i = 0; i < n; i++) begin
                readByte(i < n - 1, (i + 1 < n) ? txBytes[i + 1] : 8'h00, got);
                checkOutput("readByte", got, txBytes[i]);
            end
            checkOutput("txReqCount", txReqCnt - tr0, n);
            checkOutput("nackCount", nackCnt - nk0, 1);
            checkOutput("sdaReleasedAfterNack", sda, 1'b1);
        end
        if (!addrByte[0]) begin
            for (int i = 0; i < n; i++) begin
                writeByte(wrBytes[i], ack);
                checkOutput("dataAck", ack, !match);
            end
            checkOutput("rxCount", rxLog.size() - rx0, match ? n : 0);
            if (match && rxLog.size() - rx0 == n) begin
                for (int i = 0; i < n; i++) checkOutput("rxByte", rxLog[rx0 + i], wrBytes[i]);
            end
        end
        if (doStop) begin
            st0 = stopCnt;
            stopCond();
            waitClk(2);
            checkOutput("stopPulse", stopCnt - st0, 1);
            checkOutput("busyAfterStop", busy, 1'b0);
            checkOutput("sdaIdle", sda, 1'b1);
        end
    endtask

    initial begin
        logic       ack;
        logic       s;
        int         rx0, st0, n;
        logic [7:0] addrByte;

        waitClk(4);
        checkOutput("rstSda", sda, 1'b1);
        checkOutput("rstBusy", busy, 1'b0);
        checkOutput("rstAddrRw", addr_rw, 1'b0);
        checkOutput("rstRxData", rx_data, 8'h00);
        checkOutput("rstPulses", {tx_req, rx_valid, nack_rcvd, stop_det}, 4'b0000);
        rst_n = 1'b1;
        waitClk(4);

        $display("[TB] write A0 3C");
        wrBytes[0] = 8'h3C;
        runTransfer(8'hA0, 1, 1'b1);
        checkOutput("rxDataHeld", rx_data, 8'h3C);

        $display("[TB] read 96 5A");
        txBytes[0] = 8'h96;
        txBytes[1] = 8'h5A;
        runTransfer(8'hA1, 2, 1'b1);

        $display("[TB] wrong address A2");
        wrBytes[0] = 8'h77;
        runTransfer(8'hA2, 1, 1'b1);

        $display("[TB] repeated start");
        wrBytes[0] = 8'h10;
        runTransfer(8'hA0, 1, 1'b0);
        txBytes[0] = 8'hC3;
        runTransfer(8'hA1, 1, 1'b1);
        checkOutput("rxAfterRestart", rx_data, 8'h10);

        $display("[TB] stop mid-byte");
        rx0 = rxLog.size();
        st0 = stopCnt;
        startCond();
        writeByte(8'hA0, ack);
        checkOutput("partialAddrAck", ack, 1'b0);
        for (int i = 0; i < 4; i++) applyStimulus(i[0], s);
        stopCond();
        waitClk(2);
        checkOutput("partialNoRx", rxLog.size() - rx0, 0);
        checkOutput("partialStop", stopCnt - st0, 1);
        checkOutput("partialBusy", busy, 1'b0);
        checkOutput("partialSda", sda, 1'b1);
        wrBytes[0] = 8'h5F;
        runTransfer(8'hA0, 1, 1'b1);

        $display("[TB] general call");
        wrBytes[0] = 8'h06;
        runTransfer(8'h00, 1, 1'b1);
        runTransfer(8'h01, 1, 1'b1);

        $display("[TB] random transfers");
        for (int t = 0; t < 10; t++) begin
            addrByte[0] = 1'($urandom_range(0, 1));
            addrByte[7:1] = ($urandom_range(0, 3) != 0) ? SLAVE_ADDR : 7'($urandom);
            n = $urandom_range(1, 3);
            for (int i = 0; i < 4; i++) begin
                wrBytes[i] = 8'($urandom);
                txBytes[i] = 8'($urandom);
            end
            runTransfer(addrByte, n, 1'b1);
        end

        $display("[TB] reset while driving");
        txBytes[0] = 8'h12;
        tx_data = 8'h12;
        startCond();
        writeByte(8'hA1, ack);
        checkOutput("rstTestAddrAck", ack, 1'b0);
        waitClk(Q);
        checkOutput("txDrivesLow", sda, 1'b0);
        rst_n = 1'b0;
        waitClk(1);
        checkOutput("midRstSda", sda, 1'b1);
        checkOutput("midRstBusy", busy, 1'b0);
        checkOutput("midRstAddrRw", addr_rw, 1'b0);
        checkOutput("midRstRxData", rx_data, 8'h00);
        checkOutput("midRstPulses", {tx_req, rx_valid, nack_rcvd, stop_det}, 4'b0000);
        waitClk(2);
        rst_n = 1'b1;
        waitClk(2);
        stopCond();
        waitClk(2);

        checkOutput("noRxStopOverlap", overlapCnt, 0);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
